sd_sector_buffer: RTL and testbench
===================================

Name: sd_sector_buffer

Overview:
- Ping-pong sector buffer directly downstream of sd_bus_master.
- Captures the 512-byte data blocks the SD master reads from the card and holds each one until it is complete and intact.
- Re-emits each good sector as a ready/valid byte stream for the frame decoder.
- Decouples SD read timing (card latency, CRC aborts) from the consumer; runs entirely in the 100 MHz system domain.

Parameters:
- DATA_W, 8, width of one data beat in bits.
- SECTOR_BYTES, 512, beats per sector; must be a power of two.
- ADDR_W, $clog2(SECTOR_BYTES), index width within one bank.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- wr_valid  input  1  write beat present.
- wr_data  input  DATA_W  write beat.
- wr_last  input  1  final beat of sector; qualified by wr_valid.
- wr_abort  input  1  pulse: discard the sector being filled (CRC or command error).
- wr_ready  output  1  buffer can accept a write beat this cycle.
- rd_valid  output  1  read beat present.
- rd_data  output  DATA_W  read beat.
- rd_last  output  1  final beat of the sector being drained.
- rd_ready  input  1  consumer accepts the beat.
- sectors_dropped  output  16  count of discarded sectors (optional feature).

Behaviour:
- Two banks of SECTOR_BYTES x DATA_W, each a sync-read, sync-write RAM.
- Per-bank state: EMPTY, FILLING, FULL, DRAINING.
- Write bank pointer wb and read bank pointer rb start at bank 0 and toggle independently.
- Reset values: both banks EMPTY, wb = rb = 0, write and read indices 0, bad flag 0, wr_ready = 0 while reset is held, rd_valid = 0, rd_last = 0, rd_data = 0, sectors_dropped = 0.
- wr_ready = 1 when bank[wb] is EMPTY or FILLING.
- A write beat is accepted when wr_valid && wr_ready.
  - The first accepted beat moves the bank from EMPTY to FILLING.
  - The write index increments by 1 for each accepted beat.
- Commit:
  - Condition: accepted beat with wr_last, index == SECTOR_BYTES-1, and bad flag clear.
  - Effect: bank goes to FULL on the next edge, wb toggles, and the write index clears to 0.
- Short sector:
  - Condition: wr_last with index < SECTOR_BYTES-1.
  - Effect: the bank returns to EMPTY and wb is unchanged.
- Overflow:
  - Condition: an accepted beat when index == SECTOR_BYTES-1 and wr_last = 0.
  - Effect: set the bad flag and drop further beats. The index saturates and does not wrap.
  - At the next wr_last the bank returns to EMPTY and the bad flag clears.
- wr_abort: bank[wb] returns to EMPTY and the index clears in the same cycle. The abort wins over a simultaneous beat, wr_last or commit.
- While wr_ready = 0, wr_valid is ignored and nothing is written.
- Read side:
  - When bank[rb] is FULL it moves to DRAINING.
  - The RAM address is combinational: rd_idx + (rd_valid && rd_ready).
  - rd_data is the registered RAM output.
  - rd_valid rises 2 edges after the commit edge. Throughput is 1 beat/cycle with rd_ready held high.
- rd_last = 1 on beat index SECTOR_BYTES-1.
  - On the rd_last handshake the bank goes to EMPTY and rb toggles.
  - If the other bank is FULL, rd_valid drops for exactly 1 cycle (RAM read), then resumes.
- rd_valid and rd_data hold stable while rd_ready = 0.
- Simultaneous commit to bank X and drain-completion of bank Y in the same cycle: both take effect. wr_ready stays 1 if bank[!wb] was just freed.
- Reset asserted mid-transfer: all state returns to reset values asynchronously. Partial sectors are lost and no output glitch is permitted beyond the async clear.

Optional Feature:
- SD_SECTOR_BUF_STATS_EN
- With the macro: sectors_dropped increments (saturating at 0xFFFF) on every short, overflow or aborted sector.
- Without the macro: sectors_dropped is tied to 0 and no counter logic is synthesized.

Decomposition:
- Shared package sd_pkg holds:
  - bank state enum: EMPTY=2'd0, FILLING=2'd1, FULL=2'd2, DRAINING=2'd3;
  - SD_SECTOR_BYTES=512;
  - SD_DATA_W=8.
- One sub-module, sd_sector_bank_ram: single-bank sync RAM with a write port and a registered read port, instantiated twice.

Test Plan:
- Write 512 beats 0x00..0xFF,0x00..0xFF with wr_last on beat 512, rd_ready=1 -> rd_valid rises 2 cycles after commit; 512 beats match the input; rd_last on the 512th; sectors_dropped=0.
- Write 3 sectors back-to-back with rd_ready=0 -> wr_ready falls after sector 2 commits. Raise rd_ready -> sector 1 drains; wr_ready returns 1 cycle after its rd_last; the 3-sector order is preserved.
- wr_last on beat 100 -> no rd_valid; bank is reusable and the next full sector is output intact; sectors_dropped=1 (with macro).
- 520 beats without wr_last, then wr_last -> no output; no wrap into beat 0; sectors_dropped=1.
- wr_abort at beat 300 together with wr_valid -> sector discarded; the following full sector is output correctly.
- Assert reset mid-drain at beat 200 -> rd_valid=0 and wr_ready=0 during reset; after release both banks are empty and the next sector is output from beat 0.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD read path: per-bank state encoding and default geometry.
package sd_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_e;

   localparam int SD_SECTOR_BYTES = 512;
   localparam int SD_DATA_W       = 8;

endpackage

// File: rtl/sd_sector_bank_ram.sv
// One sector bank: synchronous-write RAM with an enable-gated registered read port
// whose output register (not the array) clears on reset.
module sd_sector_bank_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // NOTE: flops use <= so every register samples pre-edge values independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_sector_buffer.sv
// Ping-pong sector buffer between the SD bus master and the frame decoder.
// Define SD_SECTOR_BUF_STATS_EN to build the saturating sectors_dropped counter.
module sd_sector_buffer
   import sd_pkg::*;
#(
   parameter int DATA_W       = SD_DATA_W,
   parameter int SECTOR_BYTES = SD_SECTOR_BYTES,
   parameter int ADDR_W       = $clog2(SECTOR_BYTES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   input  logic              wr_abort,
   output logic              wr_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic [15:0]       sectors_dropped
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SECTOR_BYTES - 1);

   bank_state_e       bank_st_q [2];
   bank_state_e       bank_st_d [2];
   logic              wb_q, wb_d, rb_q, rb_d;
   logic [ADDR_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic              bad_q, bad_d;
   logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;

   logic              wr_open, wr_accept, wr_we, rd_hs, rd_re;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] ram_rdata [2];

   assign wr_open   = (bank_st_q[wb_q] == EMPTY) || (bank_st_q[wb_q] == FILLING);
   assign wr_ready  = reset && wr_open;
   assign wr_accept = wr_valid && wr_ready;
   assign rd_hs     = rd_valid_q && rd_ready;
   assign rd_re     = (bank_st_q[rb_q] == DRAINING);
   // Look one beat ahead on a handshake so the registered RAM output keeps 1 beat/cycle.
   assign rd_addr   = rd_idx_q + ADDR_W'(rd_hs);

   // NOTE: every _d gets its hold value first, so no path through the branches can infer a latch.
   always_comb begin
      bank_st_d  = bank_st_q;
      wb_d       = wb_q;
      rb_d       = rb_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      bad_d      = bad_q;
      rd_valid_d = rd_valid_q;
      wr_we      = 1'b0;

      if (wr_open) begin
         if (wr_abort) begin
            bank_st_d[wb_q] = EMPTY;
            wr_idx_d        = '0;
            bad_d           = 1'b0;
         end else if (wr_accept) begin
            if (bad_q) begin
               // Overflowed sector: swallow beats until its wr_last, then free the bank.
               if (wr_last) begin
                  bank_st_d[wb_q] = EMPTY;
                  wr_idx_d        = '0;
                  bad_d           = 1'b0;
               end
            end else begin
               wr_we = 1'b1;
               if (wr_last) begin
                  wr_idx_d = '0;
                  if (wr_idx_q == LAST_IDX) begin
                     bank_st_d[wb_q] = FULL;
                     wb_d            = ~wb_q;
                  end else begin
                     bank_st_d[wb_q] = EMPTY;
                  end
               end else begin
                  bank_st_d[wb_q] = FILLING;
                  if (wr_idx_q == LAST_IDX) bad_d = 1'b1;
                  else                      wr_idx_d = wr_idx_q + ADDR_W'(1);
               end
            end
         end
      end

      case (bank_st_q[rb_q])
         FULL:     bank_st_d[rb_q] = DRAINING;
         DRAINING: begin
            if (!rd_valid_q) begin
               rd_valid_d = 1'b1;
            end else if (rd_hs) begin
               if (rd_idx_q == LAST_IDX) begin
                  bank_st_d[rb_q] = EMPTY;
                  rb_d            = ~rb_q;
                  rd_idx_d        = '0;
                  rd_valid_d      = 1'b0;
                  // Start the waiting bank now so the stream pauses for only the RAM read cycle.
                  if (bank_st_q[~rb_q] == FULL) bank_st_d[~rb_q] = DRAINING;
               end else begin
                  rd_idx_d = rd_idx_q + ADDR_W'(1);
               end
            end
         end
         default: ;
      endcase

      rd_last_d = rd_valid_d && (rd_idx_d == LAST_IDX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_st_q  <= '{EMPTY, EMPTY};
         wb_q       <= 1'b0;
         rb_q       <= 1'b0;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         bad_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         bank_st_q  <= bank_st_d;
         wb_q       <= wb_d;
         rb_q       <= rb_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         bad_q      <= bad_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      sd_sector_bank_ram #(
         .DATA_W (DATA_W),
         .DEPTH  (SECTOR_BYTES),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .clk     (clk),
         .rst_n   (reset),
         .we_i    (wr_we && (wb_q == 1'(b))),
         .waddr_i (wr_idx_q),
         .wdata_i (wr_data),
         .re_i    (rd_re && (rb_q == 1'(b))),
         .raddr_i (rd_addr),
         .rdata_o (ram_rdata[b])
      );
   end

   assign rd_valid = rd_valid_q;
   assign rd_last  = rd_last_q;
   assign rd_data  = ram_rdata[rb_q];

`ifdef SD_SECTOR_BUF_STATS_EN
   logic        drop_evt;
   logic [15:0] dropped_q;

   // A sector is lost on abort of an open sector, or on wr_last that does not commit.
   assign drop_evt = wr_open && (wr_abort ? ((bank_st_q[wb_q] == FILLING) || wr_accept)
                                          : (wr_accept && wr_last && (bad_q || (wr_idx_q != LAST_IDX))));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                      dropped_q <= '0;
      else if (drop_evt && (dropped_q != 16'hFFFF))    dropped_q <= dropped_q + 16'd1;
   end

   assign sectors_dropped = dropped_q;
`else
   assign sectors_dropped = '0;
`endif

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Self-checking bench for sd_sector_buffer: sector-level reference model feeding a
// scoreboard queue, with an independent output monitor.
module tb_sd_sector_buffer;

   localparam int SECTOR      = 512;
   localparam int BEAT_BUDGET = 5000;
`ifdef SD_SECTOR_BUF_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic        clk, reset;
   logic        wr_valid, wr_last, wr_abort, wr_ready;
   logic [7:0]  wr_data;
   logic        rd_valid, rd_last, rd_ready;
   logic [7:0]  rd_data;
   logic [15:0] sectors_dropped;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    out_cnt  = 0;
   int    model_dropped = 0;
   int    rd_mode  = 0;
   beat_t exp_q[$];

   sd_sector_buffer dut (
      .clk             (clk),
      .reset           (reset),
      .wr_valid        (wr_valid),
      .wr_data         (wr_data),
      .wr_last         (wr_last),
      .wr_abort        (wr_abort),
      .wr_ready        (wr_ready),
      .rd_valid        (rd_valid),
      .rd_data         (rd_data),
      .rd_last         (rd_last),
      .rd_ready        (rd_ready),
      .sectors_dropped (sectors_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Consumer: 0 = stalled, 1 = always ready, 2 = random back-pressure.
   initial rd_ready = 1'b0;
   always begin
      @(posedge clk);
      #1;
      case (rd_mode)
         1:       rd_ready = 1'b1;
         2:       rd_ready = ($urandom_range(0, 3) != 0);
         default: rd_ready = 1'b0;
      endcase
   end

   // Monitor: every handshake pops the scoreboard; stalled beats must hold.
   bit         stall_pend = 1'b0;
   logic [7:0] stall_data;
   always @(negedge clk) begin
      if (!reset) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            check("stall_valid_hold", rd_valid, 1);
            check("stall_data_hold", rd_data, stall_data);
         end
         stall_pend = rd_valid && !rd_ready;
         stall_data = rd_data;
         if (rd_valid && rd_ready) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               beat_t e;
               e = exp_q.pop_front();
               check("rd_data", rd_data, e.data);
               check("rd_last", rd_last, e.last);
            end
            out_cnt++;
         end
      end
   end

   task automatic send_beat(input logic [7:0] d, input logic last, input logic abort, output bit ok);
      int n = 0;
      wr_valid = 1'b1; wr_data = d; wr_last = last; wr_abort = abort;
      ok = 1'b0;
      while (!ok && n < BEAT_BUDGET) begin
         @(negedge clk);
         ok = wr_ready;
         @(posedge clk);
         #1;
         n++;
      end
      wr_valid = 1'b0; wr_last = 1'b0; wr_abort = 1'b0;
      if (!ok) check("wr_ready_timeout", ok, 1);
   endtask

   // Reference rule: a sector survives only as exactly SECTOR beats ending in wr_last, never aborted.
   task automatic send_sector(input int n_beats, input bit with_last, input int abort_at,
                              input bit seq_data, input bit gaps);
      beat_t      sec[$];
      bit         ok;
      logic [7:0] d;
      for (int i = 0; i < n_beats; i++) begin
         if (gaps && $urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
         d = seq_data ? 8'(i) : 8'($urandom);
         send_beat(d, with_last && (i == n_beats - 1), abort_at == i + 1, ok);
         if (!ok) return;
         sec.push_back('{data: d, last: (i == SECTOR - 1)});
         if (abort_at == i + 1) break;
      end
      if (abort_at != 0 && abort_at <= n_beats)  model_dropped++;
      else if (with_last && n_beats == SECTOR)   foreach (sec[j]) exp_q.push_back(sec[j]);
      else if (with_last)                        model_dropped++;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 4 * BEAT_BUDGET) begin
         @(posedge clk);
         n++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("drain_empty", exp_q.size(), 0);
      check("idle_rd_valid", rd_valid, 0);
      check("sectors_dropped", sectors_dropped, STATS ? model_dropped : 0);
   endtask

   initial begin
      int n;
      int base;
      wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; wr_abort = 1'b0;
      reset = 1'b0;
      #3;
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_dropped", sectors_dropped, 0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      check("post_rst_wr_ready", wr_ready, 1);
      @(posedge clk);
      #1;

      // Single counting sector, consumer always ready: rd_valid rises two edges after commit.
      rd_mode = 1;
      send_sector(SECTOR, 1, 0, 1, 0);
      @(posedge clk); #1;
      check("latency_edge1_rd_valid", rd_valid, 0);
      @(posedge clk); #1;
      check("latency_edge2_rd_valid", rd_valid, 1);
      wait_drain();

      // Three sectors with the consumer stalled: the third must wait for bank 0 to free.
      rd_mode = 0;
      send_sector(SECTOR, 1, 0, 0, 0);
      send_sector(SECTOR, 1, 0, 0, 0);
      @(negedge clk);
      check("both_full_wr_ready", wr_ready, 0);
      @(posedge clk); #1;
      fork
         send_sector(SECTOR, 1, 0, 0, 0);
         begin
            repeat (4) @(negedge clk);
            check("stalled_wr_ready", wr_ready, 0);
            rd_mode = 1;
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(rd_valid && rd_last && rd_ready) && n < 3 * SECTOR);
            check("first_rd_last_seen", rd_valid && rd_last && rd_ready, 1);
            check("wr_ready_at_rd_last", wr_ready, 0);
            @(negedge clk);
            check("wr_ready_after_rd_last", wr_ready, 1);
            check("bank_switch_gap", rd_valid, 0);
            @(negedge clk);
            check("bank_switch_resume", rd_valid, 1);
         end
      join
      wait_drain();

      // Short sector, then a good one through the same bank.
      send_sector(100, 1, 0, 0, 0);
      send_sector(SECTOR, 1, 0, 0, 0);
      wait_drain();

      // Overflow: 520 beats with no wr_last, then wr_last; next sector must be intact.
      send_sector(521, 1, 0, 0, 0);
      send_sector(SECTOR, 1, 0, 1, 0);
      wait_drain();

      // Abort together with beat 300.
      send_sector(SECTOR, 1, 300, 0, 0);
      send_sector(SECTOR, 1, 0, 0, 0);
      wait_drain();

      // Random mix of good, short, aborted and overflowing sectors under back-pressure.
      rd_mode = 2;
      for (int s = 0; s < 8; s++) begin
         int k;
         k = $urandom_range(0, 9);
         if (k <= 5)      send_sector(SECTOR, 1, 0, 0, 1);
         else if (k <= 7) send_sector($urandom_range(1, SECTOR - 1), 1, 0, 0, 1);
         else if (k == 8) send_sector(SECTOR, 1, $urandom_range(1, SECTOR), 0, 1);
         else             send_sector($urandom_range(SECTOR + 1, SECTOR + 18), 1, 0, 0, 1);
      end
      wait_drain();

      // Reset in the middle of draining a sector.
      rd_mode = 1;
      base = out_cnt;
      send_sector(SECTOR, 1, 0, 0, 0);
      n = 0;
      while (out_cnt < base + 200 && n < BEAT_BUDGET) begin
         @(posedge clk);
         n++;
      end
      check("mid_drain_reached", out_cnt >= base + 200, 1);
      @(negedge clk);
      #2 reset = 1'b0;
      exp_q.delete();
      model_dropped = 0;
      #1;
      check("mid_rst_rd_valid", rd_valid, 0);
      check("mid_rst_wr_ready", wr_ready, 0);
      check("mid_rst_rd_last", rd_last, 0);
      check("mid_rst_rd_data", rd_data, 0);
      check("mid_rst_dropped", sectors_dropped, 0);
      repeat (2) @(negedge clk);
      check("held_rst_rd_valid", rd_valid, 0);
      check("held_rst_wr_ready", wr_ready, 0);
      #2 reset = 1'b1;
      @(negedge clk);
      check("rel_wr_ready", wr_ready, 1);
      check("rel_rd_valid", rd_valid, 0);
      @(posedge clk); #1;
      send_sector(SECTOR, 1, 0, 1, 0);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
